filter_bank_classifier: RTL and testbench
=========================================

// Module: filter_bank_classifier
// PURPOSE
// Parametrised capture/classify controller for the matched-filter bank. Loads NUM_FILTERS fingerprints from a byte stream,
// captures CAPTURE_LENGTH samples on trigger, replays them SWEEPS times to the shared filter input, tracks each filter's peak
// score, then reports the best-matching filter index (argmax with threshold). Sits between sample source, SD loader and filters.
// PARAMETERS
// SAMPLE_DATA_WIDTH  8     sample / fingerprint width (bits)
// CAPTURE_LENGTH     1000  samples per capture and per fingerprint
// NUM_FILTERS        10    filters in bank (>=2)
// SCORE_WIDTH        32    signed score width per filter
// SWEEPS             2001  replay passes per classification (>=1)
// PASS_GAP           4     idle cycles after each pass's last sample (>=2)
// SCORE_LATENCY      4     cycles after final pass before DECIDE (drains filter pipeline)
// THRESHOLD          0     signed min peak score for a match
// PORTS
// clk            in   1                          clock
// rst            in   1                          async reset, active-high
// trigger        in   1                          start capture (IDLE only)
// in_valid       in   1                          sample strobe
// in_data        in   SAMPLE_DATA_WIDTH          sample
// load_valid     in   1                          fingerprint byte strobe
// load_data      in   8                          fingerprint byte (low SAMPLE_DATA_WIDTH bits used)
// load_restart   in   1                          clear load counter
// load_done      out  1                          all NUM_FILTERS*CAPTURE_LENGTH bytes loaded
// fp_we          out  NUM_FILTERS                one-hot fingerprint RAM write enable
// fp_addr        out  clog2(CAPTURE_LENGTH)      fingerprint RAM address
// fp_data        out  SAMPLE_DATA_WIDTH          fingerprint RAM data
// filt_valid     out  1                          sample to filters valid
// filt_data      out  SAMPLE_DATA_WIDTH          sample to filters
// score_valid    in   1                          all scores valid (filters are lock-step)
// scores         in   NUM_FILTERS*SCORE_WIDTH    signed scores, filter k at [k*SCORE_WIDTH +: SCORE_WIDTH]
// busy           out  1                          state != IDLE
// result_valid   out  1                          1-cycle result strobe
// result_match   out  1                          best peak >= THRESHOLD
// result_class   out  clog2(NUM_FILTERS)         best filter index
// result_score   out  SCORE_WIDTH                best peak score
// dump_valid/dump_data/dump_ready  out/out/in  1/SAMPLE_DATA_WIDTH/1  capture dump stream
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, load counter 0, peaks = most negative SCORE_WIDTH value.
// - Load path (independent of state): registered, 1-cycle latency. Byte n -> fp_we[n/CAPTURE_LENGTH]=1, fp_addr=n%CAPTURE_LENGTH.
//   Bytes with n >= NUM_FILTERS*CAPTURE_LENGTH ignored (fp_we=0); load_done=1 from then. load_restart wins over load_valid same cycle.
// - IDLE: trigger -> CAPTURE, write addr 0. trigger in any other state ignored.
// - CAPTURE: each in_valid writes in_data at next address; after CAPTURE_LENGTH writes -> DUMP (macro) else FILTER.
// - FILTER: pass p=0..SWEEPS-1 lasts CAPTURE_LENGTH+PASS_GAP cycles; buffer read has 2-cycle latency; filt_valid high exactly
//   CAPTURE_LENGTH cycles per pass carrying samples 0..CAPTURE_LENGTH-1 in order. Peaks cleared on FILTER entry.
//   Every score_valid in FILTER/drain: peak[k] = max(peak[k], scores[k]) (signed compare).
//   After last pass wait SCORE_LATENCY cycles -> DECIDE.
// - DECIDE: sequential scan, one filter per cycle (NUM_FILTERS cycles); strict > so ties pick lowest index.
//   Then result_valid pulses 1 cycle, result_* update (held until next result), result_match = best >= THRESHOLD, -> IDLE.
// - score_valid outside FILTER/drain ignored. Async rst mid-operation aborts; result_* cleared to 0.
// CONFIGURATION
// FILTER_BANK_CLASSIFIER_DUMP_EN defined: DUMP state between CAPTURE and FILTER streams samples 0..CAPTURE_LENGTH-1 on
//   dump_valid/dump_data; transfer on dump_valid&&dump_ready; dump_valid held with data stable until accepted; then FILTER.
// Not defined: no DUMP state (CAPTURE -> FILTER directly), dump_valid tied 0, dump_data tied 0, dump_ready ignored.
// TESTING (CAPTURE_LENGTH=8, NUM_FILTERS=3, SWEEPS=2, PASS_GAP=4, SCORE_LATENCY=4, THRESHOLD=0)
// 1 Load bytes 0..23 -> fp_we 001 addr 0..7, 010 addr 0..7, 100 addr 0..7; load_done=1; byte 24 gives fp_we=000.
// 2 trigger, samples 10..17 -> filt_valid 8 cycles/pass, data 10..17, twice, 4-cycle gap between passes.
// 3 scores (5,9,-3) then (7,2,1) -> result_valid once, class=1, score=9, match=1.
// 4 all scores -5 -> class=0, score=-5, match=0; tie (9,9,1) -> class=0.
// 5 rst asserted mid-FILTER -> busy, filt_valid, result_* =0 immediately; new trigger restarts cleanly.
// 6 DUMP_EN, dump_ready toggling 1/0 -> 8 bytes 10..17 in order, none dropped or repeated, then FILTER.

Source files
------------

// File: rtl/filter_bank_classifier.sv
// filter_bank_classifier: capture, replay and argmax classification for a matched-filter bank
// Optional capture dump stream enabled by defining FILTER_BANK_CLASSIFIER_DUMP_EN.
module filter_bank_classifier #(
  parameter int SAMPLE_DATA_WIDTH = 8,
  parameter int CAPTURE_LENGTH    = 1000,
  parameter int NUM_FILTERS       = 10,
  parameter int SCORE_WIDTH       = 32,
  parameter int SWEEPS            = 2001,
  parameter int PASS_GAP          = 4,
  parameter int SCORE_LATENCY     = 4,
  parameter int THRESHOLD         = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  trigger,
  input  logic                                  in_valid,
  input  logic [SAMPLE_DATA_WIDTH-1:0]          in_data,
  input  logic                                  load_valid,
  input  logic [7:0]                            load_data,
  input  logic                                  load_restart,
  output logic                                  load_done,
  output logic [NUM_FILTERS-1:0]                fp_we,
  output logic [$clog2(CAPTURE_LENGTH)-1:0]     fp_addr,
  output logic [SAMPLE_DATA_WIDTH-1:0]          fp_data,
  output logic                                  filt_valid,
  output logic [SAMPLE_DATA_WIDTH-1:0]          filt_data,
  input  logic                                  score_valid,
  input  logic [NUM_FILTERS*SCORE_WIDTH-1:0]    scores,
  output logic                                  busy,
  output logic                                  result_valid,
  output logic                                  result_match,
  output logic [$clog2(NUM_FILTERS)-1:0]        result_class,
  output logic [SCORE_WIDTH-1:0]                result_score,
  output logic                                  dump_valid,
  output logic [SAMPLE_DATA_WIDTH-1:0]          dump_data,
  input  logic                                  dump_ready
);
  localparam int AW = $clog2(CAPTURE_LENGTH);
  localparam int CW = $clog2(NUM_FILTERS);
  localparam int GW = $clog2(CAPTURE_LENGTH + PASS_GAP);
  localparam int PW = $clog2(SWEEPS) + 1;
  localparam int LW = $clog2(SCORE_LATENCY) + 1;
  localparam int FW = $clog2(NUM_FILTERS + 1);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_FILTER  = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_DECIDE  = 3'd5;
  localparam logic signed [SCORE_WIDTH-1:0] MIN = {1'b1, {(SCORE_WIDTH-1){1'b0}}};
  localparam logic signed [SCORE_WIDTH-1:0] THR = SCORE_WIDTH'(THRESHOLD);
  logic [2:0] state;
  logic [AW-1:0] wptr, laddr, raddr;
  logic [GW-1:0] cyc;
  logic [PW-1:0] pass;
  logic [LW-1:0] lat;
  logic [CW-1:0] idx, bidx, nb_idx;
  logic [FW-1:0] lfil;
  logic signed [SCORE_WIDTH-1:0] best, nb_score;
  logic signed [SCORE_WIDTH-1:0] peak [NUM_FILTERS];
  logic signed [SCORE_WIDTH-1:0] sc [NUM_FILTERS];
  logic [SAMPLE_DATA_WIDTH-1:0] mem [CAPTURE_LENGTH];
  logic [SAMPLE_DATA_WIDTH-1:0] rd_d;
  logic rd_v, nb_gt;
  for (genvar k = 0; k < NUM_FILTERS; k++) begin : g_sc
    assign sc[k] = scores[k*SCORE_WIDTH +: SCORE_WIDTH];
  end
  assign busy      = state != S_IDLE;
  assign load_done = lfil == FW'(NUM_FILTERS);
  assign raddr     = cyc[AW-1:0];
  assign nb_gt     = peak[idx] > best;
  assign nb_score  = nb_gt ? peak[idx] : best;
  assign nb_idx    = nb_gt ? idx : bidx;
`ifdef FILTER_BANK_CLASSIFIER_DUMP_EN
  localparam logic [2:0] S_DUMP = 3'd2;
  logic [AW-1:0] dptr;
  assign dump_valid = state == S_DUMP;
  assign dump_data  = dump_valid ? mem[dptr] : '0;
`else
  logic unused_dump;
  assign unused_dump = dump_ready;
  assign dump_valid  = 1'b0;
  assign dump_data   = '0;
`endif
  // Fingerprint loader: walks filter index and address, ignoring bytes once the bank is full
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lfil <= '0;
      laddr <= '0;
      fp_we <= '0;
      fp_addr <= '0;
      fp_data <= '0;
    end else if (load_restart) begin
      lfil <= '0;
      laddr <= '0;
      fp_we <= '0;
    end else if (load_valid && !load_done) begin
      fp_we <= NUM_FILTERS'(1) << lfil;
      fp_addr <= laddr;
      fp_data <= load_data[SAMPLE_DATA_WIDTH-1:0];
      laddr <= (laddr == AW'(CAPTURE_LENGTH-1)) ? '0 : laddr + 1'b1;
      lfil <= (laddr == AW'(CAPTURE_LENGTH-1)) ? lfil + 1'b1 : lfil;
    end else
      fp_we <= '0;
  // Capture buffer with a registered read port (first stage of the replay pipeline)
  always_ff @(posedge clk) begin
    if (state == S_CAPTURE && in_valid) mem[wptr] <= in_data;
    rd_d <= mem[raddr];
  end
  // Second replay stage: the valid flag tracks the read address two cycles late
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_v <= 1'b0;
      filt_valid <= 1'b0;
      filt_data <= '0;
    end else begin
      rd_v <= state == S_FILTER && cyc < GW'(CAPTURE_LENGTH);
      filt_valid <= rd_v;
      filt_data <= rd_v ? rd_d : '0;
    end
  // Control FSM, peak tracking and the sequential argmax scan
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      wptr <= '0;
      cyc <= '0;
      pass <= '0;
      lat <= '0;
      idx <= '0;
      bidx <= '0;
      best <= MIN;
      result_valid <= 1'b0;
      result_match <= 1'b0;
      result_class <= '0;
      result_score <= '0;
`ifdef FILTER_BANK_CLASSIFIER_DUMP_EN
      dptr <= '0;
`endif
      for (int k = 0; k < NUM_FILTERS; k++) peak[k] <= MIN;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE: if (trigger) state <= S_CAPTURE;
        S_CAPTURE: if (in_valid) begin
          wptr <= (wptr == AW'(CAPTURE_LENGTH-1)) ? '0 : wptr + 1'b1;
`ifdef FILTER_BANK_CLASSIFIER_DUMP_EN
          if (wptr == AW'(CAPTURE_LENGTH-1)) state <= S_DUMP;
`else
          if (wptr == AW'(CAPTURE_LENGTH-1)) state <= S_FILTER;
`endif
        end
`ifdef FILTER_BANK_CLASSIFIER_DUMP_EN
        S_DUMP: if (dump_ready) begin
          dptr <= (dptr == AW'(CAPTURE_LENGTH-1)) ? '0 : dptr + 1'b1;
          if (dptr == AW'(CAPTURE_LENGTH-1)) state <= S_FILTER;
        end
`endif
        S_FILTER: if (cyc == GW'(CAPTURE_LENGTH+PASS_GAP-1)) begin
          cyc <= '0;
          pass <= (pass == PW'(SWEEPS-1)) ? '0 : pass + 1'b1;
          if (pass == PW'(SWEEPS-1)) state <= S_DRAIN;
        end else
          cyc <= cyc + 1'b1;
        S_DRAIN: begin
          lat <= (lat == LW'(SCORE_LATENCY-1)) ? '0 : lat + 1'b1;
          if (lat == LW'(SCORE_LATENCY-1)) state <= S_DECIDE;
        end
        S_DECIDE: if (idx == CW'(NUM_FILTERS-1)) begin
          state <= S_IDLE;
          idx <= '0;
          bidx <= '0;
          best <= MIN;
          result_valid <= 1'b1;
          result_class <= nb_idx;
          result_score <= nb_score;
          result_match <= nb_score >= THR;
        end else begin
          idx <= idx + 1'b1;
          bidx <= nb_idx;
          best <= nb_score;
        end
        default: state <= S_IDLE;
      endcase
      for (int k = 0; k < NUM_FILTERS; k++)
        if (state == S_CAPTURE) peak[k] <= MIN;
        else if ((state == S_FILTER || state == S_DRAIN) && score_valid && sc[k] > peak[k]) peak[k] <= sc[k];
    end
endmodule

// File: tb/tb_filter_bank_classifier.sv
// tb_filter_bank_classifier: scoreboard bench for the classifier with a small bank
module tb_filter_bank_classifier;
  localparam int CL = 8;
  localparam int NF = 3;
  typedef struct packed {logic [1:0] c; logic [31:0] s; logic m;} res_t;
  logic clk = 0, rst = 1, trigger = 0, in_valid = 0, load_valid = 0, load_restart = 0;
  logic score_valid = 0, dump_ready = 0;
  logic [7:0] in_data = 0, load_data = 0;
  logic [95:0] scores = '0;
  logic load_done, filt_valid, busy, result_valid, result_match, dump_valid;
  logic [2:0] fp_we, fp_addr;
  logic [7:0] fp_data, filt_data, dump_data;
  logic [1:0] result_class;
  logic [31:0] result_score;
  logic [13:0] exp_fp [$];
  logic [7:0] exp_filt [$];
  logic [7:0] exp_dump [$];
  res_t exp_res [$];
  int n_vec = 0, n_fail = 0, seen = 0, gap = 0;

  filter_bank_classifier #(
    .SAMPLE_DATA_WIDTH(8), .CAPTURE_LENGTH(CL), .NUM_FILTERS(NF), .SCORE_WIDTH(32),
    .SWEEPS(2), .PASS_GAP(4), .SCORE_LATENCY(4), .THRESHOLD(0)
  ) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .in_valid(in_valid), .in_data(in_data),
    .load_valid(load_valid), .load_data(load_data), .load_restart(load_restart),
    .load_done(load_done), .fp_we(fp_we), .fp_addr(fp_addr), .fp_data(fp_data),
    .filt_valid(filt_valid), .filt_data(filt_data), .score_valid(score_valid), .scores(scores),
    .busy(busy), .result_valid(result_valid), .result_match(result_match),
    .result_class(result_class), .result_score(result_score),
    .dump_valid(dump_valid), .dump_data(dump_data), .dump_ready(dump_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] pack(input int a, input int b, input int c);
    return {32'(c), 32'(b), 32'(a)};
  endfunction

  always @(negedge clk) begin
    if (!busy) begin
      seen = 0;
      gap = 0;
    end
    if (fp_we != 0) begin
      if (exp_fp.size() == 0) chk("fp_unexpected", 64'(fp_we), 0);
      else chk("fp_write", 64'({fp_we, fp_addr, fp_data}), 64'(exp_fp.pop_front()));
    end
    if (filt_valid) begin
      if (seen > 0 && gap > 0) chk("pass_gap", 64'(gap), 4);
      gap = 0;
      seen++;
      if (exp_filt.size() == 0) chk("filt_unexpected", 64'(filt_data), 64'hdead);
      else chk("filt_data", 64'(filt_data), 64'(exp_filt.pop_front()));
    end else if (seen > 0) gap++;
    if (result_valid) begin
      if (exp_res.size() == 0) chk("result_unexpected", 64'(result_valid), 0);
      else chk("result", 64'({result_class, result_score, result_match}), 64'(exp_res.pop_front()));
    end
`ifdef FILTER_BANK_CLASSIFIER_DUMP_EN
    if (dump_valid && dump_ready) begin
      if (exp_dump.size() == 0) chk("dump_unexpected", 64'(dump_data), 64'hdead);
      else chk("dump_data", 64'(dump_data), 64'(exp_dump.pop_front()));
    end
`else
    if (dump_valid) chk("dump_tied", 64'(dump_valid), 0);
`endif
  end

  initial forever begin
    @(posedge clk);
    #1 dump_ready = ~dump_ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic start_op(input int base);
    trigger = 1;
    tick();
    trigger = 0;
    for (int i = 0; i < CL; i++) begin
      if (i == 3) begin
        in_valid = 0;
        tick();
      end
      in_valid = 1;
      in_data = 8'(base + i);
      exp_dump.push_back(8'(base + i));
      tick();
    end
    in_valid = 0;
`ifndef FILTER_BANK_CLASSIFIER_DUMP_EN
    exp_dump.delete();
`endif
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < CL; i++) exp_filt.push_back(8'(base + i));
  endtask

  task automatic wait_filt();
    int t = 0;
    while (!filt_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("filt_start_timeout", 64'(t < 200), 1);
  endtask

  task automatic finish_op(input logic [95:0] sa, input logic [95:0] sb, input res_t r);
    int t = 0;
    exp_res.push_back(r);
    tick();
    score_valid = 1;
    scores = sa;
    trigger = 1;
    tick();
    trigger = 0;
    scores = sb;
    tick();
    score_valid = 0;
    scores = '0;
    while (busy && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("op_timeout", 64'(t < 300), 1);
    repeat (2) tick();
    chk("filt_pending", 64'(exp_filt.size()), 0);
    chk("res_pending", 64'(exp_res.size()), 0);
    chk("res_hold", 64'({result_class, result_score, result_match}), 64'(r));
    chk("busy_idle", 64'(busy), 0);
  endtask

  initial begin
    tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_filt_valid", 64'(filt_valid), 0);
    chk("rst_result_valid", 64'(result_valid), 0);
    chk("rst_result", 64'({result_class, result_score, result_match}), 0);
    chk("rst_load_done", 64'(load_done), 0);
    chk("rst_fp_we", 64'(fp_we), 0);
    rst = 0;
    tick();
    for (int n = 0; n < NF * CL; n++) begin
      if (n == NF * CL - 1) chk("load_done_early", 64'(load_done), 0);
      load_valid = 1;
      load_data = 8'(n * 7 + 3);
      exp_fp.push_back({3'(1 << (n / CL)), 3'(n % CL), 8'(n * 7 + 3)});
      tick();
    end
    load_valid = 0;
    chk("load_done", 64'(load_done), 1);
    load_valid = 1;
    load_data = 8'hee;
    tick();
    load_valid = 0;
    chk("load_overflow_we", 64'(fp_we), 0);
    load_valid = 1;
    load_restart = 1;
    tick();
    load_restart = 0;
    chk("restart_we", 64'(fp_we), 0);
    chk("restart_done", 64'(load_done), 0);
    load_data = 8'h5a;
    exp_fp.push_back({3'b001, 3'd0, 8'h5a});
    tick();
    load_valid = 0;
    tick();
    chk("fp_pending", 64'(exp_fp.size()), 0);

    start_op(10);
    wait_filt();
    finish_op(pack(5, 9, -3), pack(7, 2, 1), '{c: 2'd1, s: 32'd9, m: 1'b1});
    start_op(20);
    wait_filt();
    finish_op(pack(-5, -5, -5), pack(-5, -5, -5), '{c: 2'd0, s: -32'sd5, m: 1'b0});
    start_op(30);
    wait_filt();
    finish_op(pack(9, 9, 1), pack(0, 0, 0), '{c: 2'd0, s: 32'd9, m: 1'b1});

    start_op(40);
    wait_filt();
    #1 rst = 1;
    #1;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_filt_valid", 64'(filt_valid), 0);
    chk("abort_result", 64'({result_valid, result_class, result_score, result_match}), 0);
    chk("abort_load_done", 64'(load_done), 0);
    exp_filt.delete();
    exp_dump.delete();
    tick();
    rst = 0;
    tick();
    start_op(50);
    wait_filt();
    finish_op(pack(-4, 0, -1), pack(-9, -9, -9), '{c: 2'd1, s: 32'd0, m: 1'b1});

`ifdef FILTER_BANK_CLASSIFIER_DUMP_EN
    chk("dump_pending", 64'(exp_dump.size()), 0);
`else
    chk("dump_valid_tied", 64'(dump_valid), 0);
    chk("dump_data_tied", 64'(dump_data), 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
